mem_stage_lsu: RTL and testbench

// - Parametrised MEM-stage load/store unit for the RV32I pipeline. It replaces the word-only, single-cycle memory stage.
// - Adds sub-word accesses (LB/LH/LW/LBU/LHU, SB/SH/SW), a configurable data-memory depth and read latency,
//   and a valid/ready request handshake with a one-cycle response pulse back to WB.
// - Sits between EX/MEM and MEM/WB. The core holds the instruction in EX/MEM while req_ready is low.

---
 rtl/mem_stage_lsu.sv | 179 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: byte-enabled data RAM, configurable read latency, valid/ready handshake.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module mem_stage_lsu #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [2:0]  funct3,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        resp_valid,
    output logic [31:0] memData,
    output logic        misaligned
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         off_q, off_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               mis_ld_q, mis_ld_d;
    logic [31:0]        data_q, data_d;
    logic               mis_q, mis_d;
    logic [31:0]        mem_q [DEPTH];

    logic               accept;
    logic               is_load;
    logic               is_store;
    logic               mis_now;
    logic               write_en;
    logic [ADDR_W-1:0]  acc_idx;
    logic [1:0]         acc_off;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic               unused_addr;

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign memData     = data_q;
    assign misaligned  = mis_q;

    assign accept      = req_valid && req_ready;
    assign is_load     = MemRead && !MemWrite;
    assign is_store    = MemWrite && !MemRead;
    assign acc_idx     = alu_result[ADDR_W+1:2];
    assign acc_off     = alu_result[1:0];
    assign unused_addr = ^alu_result[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misalign_chk(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b001, 3'b101: misalign_chk = off[0];
            3'b010:         misalign_chk = |off;
            default:        misalign_chk = 1'b0;
        endcase
    endfunction
    assign mis_now = misalign_chk(funct3, acc_off);
`else
    assign mis_now = 1'b0;
`endif

    // Halfword lanes follow offset[1] and words ignore the offset, which force-aligns when not trapping.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b010:  extract = w;
            3'b100:  extract = {24'd0, b};
            3'b101:  extract = {16'd0, h};
            default: extract = 32'd0;
        endcase
    endfunction

    always_comb begin
        be    = 4'b0000;
        wdata = rs2_data;
        case (funct3)
            3'b000: begin
                be    = 4'b0001 << acc_off;
                wdata = {4{rs2_data[7:0]}};
            end
            3'b001: begin
                be    = acc_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rs2_data[15:0]}};
            end
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // A store coinciding with reset is dropped so reset leaves no side effects.
    assign write_en = accept && is_store && !reset && !mis_now;

    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        off_d    = off_q;
        idx_d    = idx_q;
        mis_ld_d = mis_ld_q;
        data_d   = data_q;
        mis_d    = mis_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_load) begin
                        f3_d     = funct3;
                        off_d    = acc_off;
                        idx_d    = acc_idx;
                        mis_ld_d = mis_now;
                        cnt_d    = LAT_M1;
                        state_d  = LOAD_WAIT;
                    end else begin
                        data_d  = 32'd0;
                        mis_d   = is_store ? mis_now : 1'b0;
                        state_d = RESP;
                    end
                end
            end
            LOAD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    data_d  = mis_ld_q ? 32'd0 : extract(mem_q[idx_q], f3_q, off_q);
                    mis_d   = mis_ld_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            f3_q     <= 3'd0;
            off_q    <= 2'd0;
            idx_q    <= '0;
            mis_ld_q <= 1'b0;
            data_q   <= 32'd0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            idx_q    <= idx_d;
            mis_ld_q <= mis_ld_d;
            data_q   <= data_d;
            mis_q    <= mis_d;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu (READ_LAT=3, DEPTH=1024).
`timescale 1ns/1ps
module tb_mem_stage_lsu;
    localparam int LAT = 3;
    localparam int LD_LAT = LAT + 1;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101, F_RSV = 3'b011;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [2:0]  funct3;
    logic        MemRead;
    logic        MemWrite;
    logic        resp_valid;
    logic [31:0] memData;
    logic        misaligned;

    int          total = 0;
    int          bad = 0;
    int          lat;
    int          n;
    logic [31:0] md;
    logic        mis;
    logic        flag;
    logic [31:0] exp_w10;

    mem_stage_lsu #(.DEPTH(1024), .READ_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .alu_result(alu_result), .rs2_data(rs2_data), .funct3(funct3),
        .MemRead(MemRead), .MemWrite(MemWrite), .resp_valid(resp_valid),
        .memData(memData), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $error("FAIL ready_timeout: req_ready not seen within %0d cycles", k);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic rd, input logic wr,
                       output int l, output logic [31:0] o_md, output logic o_mis);
        wait_ready();
        alu_result = a;
        rs2_data   = d;
        funct3     = f;
        MemRead    = rd;
        MemWrite   = wr;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        l = 1;
        while (!resp_valid && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!resp_valid) begin
            total++;
            bad++;
            $error("FAIL resp_timeout: resp_valid not seen within %0d cycles", l);
        end
        o_md  = memData;
        o_mis = misaligned;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; alu_result = 32'd0; rs2_data = 32'd0;
        funct3 = 3'd0; MemRead = 1'b0; MemWrite = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_resp", resp_valid, 1'b0);
        chk("rst_data", memData, 32'd0);
        chk("rst_mis", misaligned, 1'b0);

        req(32'h010, 32'hDEADBEEF, F_W, 1'b0, 1'b1, lat, md, mis);
        chk("sw_lat", lat, 1);
        chk("sw_data", md, 32'd0);
        req(32'h010, 32'h0, F_W, 1'b1, 1'b0, lat, md, mis);
        chk("lw_lat", lat, LD_LAT);
        chk("lw_data", md, 32'hDEADBEEF);
        chk("lw_mis", mis, 1'b0);

        req(32'h010, 32'h0, F_W, 1'b0, 1'b1, lat, md, mis);
        req(32'h013, 32'hFFFFFF80, F_B, 1'b0, 1'b1, lat, md, mis);
        chk("sb_lat", lat, 1);
        req(32'h013, 32'h0, F_B, 1'b1, 1'b0, lat, md, mis);
        chk("lb_data", md, 32'hFFFFFF80);
        req(32'h013, 32'h0, F_BU, 1'b1, 1'b0, lat, md, mis);
        chk("lbu_data", md, 32'h00000080);
        req(32'h010, 32'h0, F_W, 1'b1, 1'b0, lat, md, mis);
        chk("lw_after_sb", md, 32'h80000000);

        req(32'h012, 32'hABCD1234, F_H, 1'b0, 1'b1, lat, md, mis);
        req(32'h012, 32'h0, F_H, 1'b1, 1'b0, lat, md, mis);
        chk("lh_hi", md, 32'h00001234);
        req(32'h010, 32'h0, F_HU, 1'b1, 1'b0, lat, md, mis);
        chk("lhu_lo_unchanged", md, 32'h00000000);
        req(32'h010, 32'h00008001, F_H, 1'b0, 1'b1, lat, md, mis);
        req(32'h010, 32'h0, F_H, 1'b1, 1'b0, lat, md, mis);
        chk("lh_neg", md, 32'hFFFF8001);
        req(32'h010, 32'h0, F_HU, 1'b1, 1'b0, lat, md, mis);
        chk("lhu_lo", md, 32'h00008001);

        req(32'h1000, 32'hA5A5A5A5, F_W, 1'b0, 1'b1, lat, md, mis);
        req(32'h000, 32'h0, F_W, 1'b1, 1'b0, lat, md, mis);
        chk("wrap_data", md, 32'hA5A5A5A5);

        req(32'h010, 32'h0, F_RSV, 1'b1, 1'b0, lat, md, mis);
        chk("rsv_lat", lat, LD_LAT);
        chk("rsv_data", md, 32'd0);

        req(32'h000, 32'h0, F_W, 1'b1, 1'b0, lat, md, mis);
        req(32'h010, 32'hFFFFFFFF, F_W, 1'b1, 1'b1, lat, md, mis);
        chk("noop_lat", lat, 1);
        chk("noop_data", md, 32'd0);
        req(32'h010, 32'h0, F_W, 1'b0, 1'b0, lat, md, mis);
        chk("noop0_lat", lat, 1);
        req(32'h010, 32'h0, F_W, 1'b1, 1'b0, lat, md, mis);
        chk("noop_mem_intact", md, 32'h12348001);

`ifdef LSU_MISALIGN_TRAP_EN
        req(32'h011, 32'h0, F_W, 1'b1, 1'b0, lat, md, mis);
        chk("mis_lw_lat", lat, LD_LAT);
        chk("mis_lw_flag", mis, 1'b1);
        chk("mis_lw_data", md, 32'd0);
        req(32'h013, 32'h0, F_H, 1'b1, 1'b0, lat, md, mis);
        chk("mis_lh_flag", mis, 1'b1);
        chk("mis_lh_data", md, 32'd0);
        req(32'h012, 32'hFFFFFFFF, F_W, 1'b0, 1'b1, lat, md, mis);
        chk("mis_sw_lat", lat, 1);
        chk("mis_sw_flag", mis, 1'b1);
        exp_w10 = 32'h12348001;
`else
        req(32'h011, 32'h0, F_W, 1'b1, 1'b0, lat, md, mis);
        chk("algn_lw_flag", mis, 1'b0);
        chk("algn_lw_data", md, 32'h12348001);
        req(32'h013, 32'h0, F_H, 1'b1, 1'b0, lat, md, mis);
        chk("algn_lh_data", md, 32'h00001234);
        req(32'h012, 32'hFFFFFFFF, F_W, 1'b0, 1'b1, lat, md, mis);
        chk("algn_sw_flag", mis, 1'b0);
        exp_w10 = 32'hFFFFFFFF;
`endif
        req(32'h010, 32'h0, F_W, 1'b1, 1'b0, lat, md, mis);
        chk("mis_mem_check", md, exp_w10);
        chk("aligned_flag_clear", mis, 1'b0);

        wait_ready();
        alu_result = 32'h010; funct3 = F_W; MemRead = 1'b1; MemWrite = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        flag = 1'b1;
        while (!resp_valid && n < 20) begin
            if (req_ready) flag = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        MemRead = 1'b0;
        chk("hold_lat", n, LD_LAT);
        chk("hold_ready_low", flag, 1'b1);
        chk("hold_data", memData, exp_w10);
        @(posedge clk);
        #1;
        chk("hold_resp_once", resp_valid, 1'b0);
        chk("hold_idle_ready", req_ready, 1'b1);

        wait_ready();
        alu_result = 32'h010; funct3 = F_W; MemRead = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        MemRead = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rstld_ready", req_ready, 1'b1);
        chk("rstld_resp", resp_valid, 1'b0);
        chk("rstld_data", memData, 32'd0);
        n = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (resp_valid) n++;
        end
        chk("rstld_no_resp", n, 0);

        req(32'h020, 32'h0, F_W, 1'b0, 1'b1, lat, md, mis);
        wait_ready();
        alu_result = 32'h020; rs2_data = 32'h11111111; funct3 = F_W;
        MemWrite = 1'b1; req_valid = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        MemWrite = 1'b0;
        reset = 1'b0;
        chk("rstst_resp", resp_valid, 1'b0);
        req(32'h020, 32'h0, F_W, 1'b1, 1'b0, lat, md, mis);
        chk("rstst_mem", md, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
